fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Fetch stage directly upstream of the decode stage.
- Generates sequential PCs and issues requests to the instruction memory/cache port.
- Buffers returned instructions in a small FIFO and presents the head to decode on the fetch-to-decode interface (inst_e_, inst_pc, inst, dec_stall).
- Handles pipeline redirects: flushes the queue and squashes in-flight responses.

Parameters:
- ADDR, `AddrWidth, PC/address width
- INST, `InstWidth, instruction width
- QDEPTH, 4, queue entries; also the maximum number of outstanding requests (power of 2, >=2)
- RESET_PC, 0, PC loaded at reset

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset; all state clears immediately on assertion
- ic_req_  out  1  active-low request valid to instruction memory
- ic_addr  out  ADDR  request address (current fetch PC)
- ic_ready  in  1  memory accepts request this cycle; handshake = !ic_req_ && ic_ready
- ic_valid_  in  1  active-low response valid; responses return in request order
- ic_data  in  INST  response instruction
- redirect_  in  1  active-low redirect/flush from backend
- redirect_pc  in  ADDR  new fetch PC
- dec_stall  in  1  decode cannot accept; hold head
- inst_e_  out  1  active-low: head entry valid
- inst_pc  out  ADDR  PC of head entry
- inst  out  INST  head instruction

Behaviour:
- Reset values:
  - pc = RESET_PC; queue count, read/write pointers, outstanding count and drop count = 0.
  - ic_req_ = 1, inst_e_ = 1, inst_pc = 0, inst = 0.
- Credit rule: ic_req_ = 0 iff (count + outstanding) < QDEPTH and redirect_ = 1. ic_addr = pc.
- Request accept (ic_req_ = 0 && ic_ready): pc += 4 (wraps modulo 2^ADDR); outstanding += 1.
- Pc FIFO: a pc FIFO of depth QDEPTH records the address of each accepted request in issue order.
- Response (ic_valid_ = 0):
  - If drop > 0: discard the response; drop -= 1.
  - Otherwise: write {pc FIFO head, ic_data} into the queue; outstanding -= 1.
  - A response never arrives with outstanding + drop == 0; the bench asserts on this.
- Outputs are combinational from the queue head registers: inst_e_ = (count == 0).
- Pop: inst_e_ = 0 && dec_stall = 0 in cycle N → head advances at edge N+1.
- Write to an empty queue: the entry is visible (inst_e_ = 0) the cycle after the response; no bypass, so response-to-decode latency is 1 cycle.
- Simultaneous push and pop: count unchanged. Full queue with response is impossible by the credit rule.
- Redirect (redirect_ = 0 in cycle N), taking effect at edge N+1:
  - pc = redirect_pc; queue count = 0; pc FIFO cleared.
  - drop = drop + outstanding, counting any response in cycle N as already arrived and discarded; outstanding = 0.
  - No request is issued in cycle N.
  - A pop in cycle N is still a consumed instruction; the backend squashes it.
- Redirect wins over push and pop in the same cycle.
- Back-to-back redirects: the last one wins; drop accumulates.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory responses after reset release are the memory's responsibility; the memory is reset on the same reset_.
- Width rules:
  - Counts are $clog2(QDEPTH)+1 bits.
  - Drop counter is $clog2(QDEPTH)+2 bits and saturates, which is unreachable in legal use.
  - PC increment is fixed at 4; no compressed ISA.

Optional Feature:
- FETCH_PERF_EN: when defined, adds output ports perf_stall_cyc (32 b), perf_empty_cyc (32 b) and perf_drop_cnt (32 b).
  - perf_stall_cyc: cycles with inst_e_ = 0 && dec_stall = 1.
  - perf_empty_cyc: cycles with inst_e_ = 1.
  - perf_drop_cnt: discarded responses.
  - All three reset to 0 and wrap on overflow.
- Without the macro: ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC = 0x1000, ic_ready = 1, memory latency 1, dec_stall = 0 → requests 0x1000, 0x1004, 0x1008…; the first inst_e_ = 0 appears 2 cycles after the first request, with inst_pc = 0x1000, then one instruction per cycle.
- dec_stall held at 1 → exactly QDEPTH = 4 requests are issued, then ic_req_ = 1. inst_pc stays at 0x1000. Releasing the stall drains 4 entries in order and requests resume.
- 3 requests outstanding (latency 5), redirect_ = 0 with redirect_pc = 0x2000 → the 3 stale responses are dropped and the next inst_pc seen is 0x2000.
- Redirect in the same cycle as a response and a pop → queue empties and the response is discarded. The next request is 0x2000, issued 1 cycle after the redirect.
- ic_ready = 0 for 10 cycles → ic_addr is stable and pc does not advance. inst_e_ = 1 throughout; the perf_empty_cyc increment is checked when FETCH_PERF_EN is defined.
- reset_ asserted with the queue full → outputs are at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited I-memory requests and a small
// instruction queue feeding decode. Optional FETCH_PERF_EN adds performance counters.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_queue #(
    parameter int unsigned      ADDR     = `AddrWidth,
    parameter int unsigned      INST     = `InstWidth,
    parameter int unsigned      QDEPTH   = 4,
    parameter logic [ADDR-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_,
    output logic            ic_req_,
    output logic [ADDR-1:0] ic_addr,
    input  logic            ic_ready,
    input  logic            ic_valid_,
    input  logic [INST-1:0] ic_data,
    input  logic            redirect_,
    input  logic [ADDR-1:0] redirect_pc,
    input  logic            dec_stall,
    output logic            inst_e_,
    output logic [ADDR-1:0] inst_pc,
    output logic [INST-1:0] inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_empty_cyc,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = PW + 2;
    localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

    logic [ADDR-1:0] pc_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   out_q;
    logic [DW-1:0]   drop_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW-1:0]   pf_rd_q, pf_wr_q;

    logic [ADDR-1:0] pf_mem [QDEPTH];
    logic [ADDR-1:0] q_pc   [QDEPTH];
    logic [INST-1:0] q_inst [QDEPTH];

    logic            redir, resp, req, accept, resp_drop, push, pop, empty;
    logic [CW:0]     credit_sum;
    logic [DW:0]     drop_sum;
    logic [DW-1:0]   drop_redir;

    always_comb begin
        redir      = !redirect_;
        resp       = !ic_valid_;
        empty      = (count_q == '0);
        credit_sum = {1'b0, count_q} + {1'b0, out_q};
        req        = reset_ && !redir && (credit_sum < QLIM);
        accept     = req && ic_ready;
        resp_drop  = resp && (drop_q != '0);
        push       = resp && !resp_drop && (out_q != '0);
        pop        = !empty && !dec_stall;
    end

    // On redirect every outstanding request becomes stale; a response landing in the
    // redirect cycle is retired here, and the counter saturates instead of wrapping.
    always_comb begin
        drop_sum = {1'b0, drop_q} + (DW+1)'(out_q);
        if (resp && (drop_sum != '0)) begin
            drop_sum = drop_sum - (DW+1)'(1);
        end
        drop_redir = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pf_rd_q  <= '0;
            pf_wr_q  <= '0;
        end else if (redir) begin
            pc_q     <= redirect_pc;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= drop_redir;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pf_rd_q  <= '0;
            pf_wr_q  <= '0;
        end else begin
            if (accept) begin
                pc_q    <= pc_q + ADDR'(4);
                pf_wr_q <= pf_wr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                pf_rd_q  <= pf_rd_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (resp_drop) begin
                drop_q <= drop_q - DW'(1);
            end
            out_q   <= out_q + CW'(accept) - CW'(push);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            pf_mem[pf_wr_q] <= pc_q;
        end
        if (push && !redir) begin
            q_pc[wr_ptr_q]   <= pf_mem[pf_rd_q];
            q_inst[wr_ptr_q] <= ic_data;
        end
    end

    always_comb begin
        ic_req_ = !req;
        ic_addr = pc_q;
        inst_e_ = empty;
        inst_pc = empty ? '0 : q_pc[rd_ptr_q];
        inst    = empty ? '0 : q_inst[rd_ptr_q];
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perf_stall_cyc <= '0;
            perf_empty_cyc <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (!empty && dec_stall) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (empty) begin
                perf_empty_cyc <= perf_empty_cyc + 32'd1;
            end
            if (resp && (redir || resp_drop)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model with programmable latency,
// directed scenarios with hand-computed expected PC sequences, and a decoupled pop monitor.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_;
    logic        ic_req_;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic        ic_valid_ = 1'b1;
    logic [31:0] ic_data = '0;
    logic        redirect_;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        inst_e_;
    logic [31:0] inst_pc;
    logic [31:0] inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cyc, perf_empty_cyc, perf_drop_cnt;
`endif

    fetch_queue #(
        .ADDR(32), .INST(32), .QDEPTH(4), .RESET_PC(32'h0000_1000)
    ) dut (
        .clk(clk), .reset_(reset_),
        .ic_req_(ic_req_), .ic_addr(ic_addr), .ic_ready(ic_ready),
        .ic_valid_(ic_valid_), .ic_data(ic_data),
        .redirect_(redirect_), .redirect_pc(redirect_pc),
        .dec_stall(dec_stall),
        .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst)
`ifdef FETCH_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_empty_cyc(perf_empty_cyc),
        .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory model: in-order responses, each due lat cycles after its request.
    typedef struct packed { logic [31:0] addr; logic [31:0] due; } req_t;
    req_t        pend[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned req_cnt = 0;

    always @(negedge clk) begin
        if (!reset_) pend.delete();
        else if (!ic_req_ && ic_ready) begin
            pend.push_back('{addr: ic_addr, due: cyc + lat});
            req_cnt++;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        ic_valid_ = 1'b1;
        ic_data   = '0;
        if (reset_ && pend.size() != 0 && pend[0].due <= cyc) begin
            ic_valid_ = 1'b0;
            ic_data   = mem_data(pend[0].addr);
            void'(pend.pop_front());
        end
    end

    // Monitor: every instruction consumed by decode must match the scoreboard head.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_ && !ic_valid_) begin
            chk("resp_credit", 32'(dut.out_q != '0 || dut.drop_q != '0), 32'd1);
        end
        if (reset_ && !inst_e_ && !dec_stall) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got pc 0x%08h, expected no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", inst_pc, e);
                chk("pop_inst", inst, mem_data(e));
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned l, input logic stall, input logic rdy);
        reset_    = 1'b0;
        lat       = l;
        dec_stall = stall;
        ic_ready  = rdy;
        redirect_ = 1'b1;
        repeat (2) next_cyc();
        exp_q.delete();
        req_cnt = 0;
        reset_  = 1'b1;
    endtask

    task automatic drain(input string name);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            next_cyc();
            k++;
        end
        dec_stall = 1'b1;
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] perf0;
        reset_ = 1'b0; ic_ready = 1'b1; redirect_ = 1'b1; redirect_pc = '0; dec_stall = 1'b0;
        @(negedge clk);
        chk("rst_ic_req_", 32'(ic_req_), 32'd1);
        chk("rst_inst_e_", 32'(inst_e_), 32'd1);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst", inst, 32'h0);

        // Streaming, latency 1.
        do_reset(1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        @(negedge clk);
        chk("t1_req0", 32'(ic_req_), 32'd0);
        chk("t1_addr0", ic_addr, 32'h1000);
        chk("t1_empty0", 32'(inst_e_), 32'd1);
        next_cyc(); @(negedge clk);
        chk("t1_addr1", ic_addr, 32'h1004);
        chk("t1_empty1", 32'(inst_e_), 32'd1);
        next_cyc(); @(negedge clk);
        chk("t1_valid2", 32'(inst_e_), 32'd0);
        chk("t1_head2", inst_pc, 32'h1000);
        next_cyc();
        drain("t1");

        // Decode stalled: credits cap requests at QDEPTH, then drain in order.
        do_reset(1, 1'b1, 1'b1);
        repeat (8) next_cyc();
        @(negedge clk);
        chk("t2_req_cnt", 32'(req_cnt), 32'd4);
        chk("t2_req_off", 32'(ic_req_), 32'd1);
        chk("t2_head", inst_pc, 32'h1000);
        chk("t2_valid", 32'(inst_e_), 32'd0);
        next_cyc();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        dec_stall = 1'b0;
        @(negedge clk);
        chk("t2_full_no_req", 32'(ic_req_), 32'd1);
        next_cyc(); @(negedge clk);
        chk("t2_resume_req", 32'(ic_req_), 32'd0);
        chk("t2_resume_addr", ic_addr, 32'h1010);
        next_cyc();
        drain("t2");

        // Redirect with 3 outstanding requests at latency 5.
        do_reset(5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 32'(4 * i));
        repeat (3) next_cyc();
        redirect_ = 1'b0; redirect_pc = 32'h2000;
        @(negedge clk);
        chk("t3_no_req_redir", 32'(ic_req_), 32'd1);
        next_cyc();
        redirect_ = 1'b1;
        @(negedge clk);
        chk("t3_req_after", 32'(ic_req_), 32'd0);
        chk("t3_addr_after", ic_addr, 32'h2000);
        repeat (3) next_cyc();
        @(negedge clk);
        chk("t3_stale_dropped", 32'(inst_e_), 32'd1);
        next_cyc();
        chk("t3_req_cnt", 32'(req_cnt), 32'd7);
        drain("t3");

        // Redirect coinciding with a response and a pop.
        do_reset(1, 1'b0, 1'b1);
        exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
        exp_q.push_back(32'h2000); exp_q.push_back(32'h2004); exp_q.push_back(32'h2008);
        repeat (3) next_cyc();
        redirect_ = 1'b0; redirect_pc = 32'h2000;
        @(negedge clk);
        chk("t4_resp_present", 32'(ic_valid_), 32'd0);
        chk("t4_no_req_redir", 32'(ic_req_), 32'd1);
        chk("t4_pop_head", inst_pc, 32'h1004);
        next_cyc();
        redirect_ = 1'b1;
        @(negedge clk);
        chk("t4_req_after", 32'(ic_req_), 32'd0);
        chk("t4_addr_after", ic_addr, 32'h2000);
        chk("t4_flushed", 32'(inst_e_), 32'd1);
        next_cyc(); @(negedge clk);
        chk("t4_still_empty", 32'(inst_e_), 32'd1);
        next_cyc();
        drain("t4");

        // Back-to-back redirects: the last target wins.
        do_reset(5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 32'(4 * i));
        repeat (3) next_cyc();
        redirect_ = 1'b0; redirect_pc = 32'h3000;
        next_cyc();
        redirect_pc = 32'h2000;
        @(negedge clk);
        chk("t5_no_req_redir2", 32'(ic_req_), 32'd1);
        next_cyc();
        redirect_ = 1'b1;
        @(negedge clk);
        chk("t5_addr_last", ic_addr, 32'h2000);
        next_cyc();
        drain("t5");

        // Memory not ready for 10 cycles.
        do_reset(1, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        perf0 = perf_empty_cyc;
`else
        perf0 = '0;
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_addr_hold", ic_addr, 32'h1000);
            chk("t6_empty", 32'(inst_e_), 32'd1);
            next_cyc();
        end
        @(negedge clk);
        chk("t6_no_handshake", 32'(req_cnt), 32'd0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_empty", perf_empty_cyc - perf0, 32'd10);
`endif
        next_cyc();
        ic_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        drain("t6");

        // Asynchronous reset with the queue full.
        do_reset(1, 1'b1, 1'b1);
        repeat (8) next_cyc();
        @(negedge clk);
        chk("t7_full_valid", 32'(inst_e_), 32'd0);
        chk("t7_full_head", inst_pc, 32'h1000);
        chk("t7_full_no_req", 32'(ic_req_), 32'd1);
        next_cyc();
        #2;
        reset_ = 1'b0;
        #1;
        chk("t7_async_ic_req_", 32'(ic_req_), 32'd1);
        chk("t7_async_inst_e_", 32'(inst_e_), 32'd1);
        chk("t7_async_inst_pc", inst_pc, 32'h0);
        chk("t7_async_inst", inst, 32'h0);
        chk("t7_async_addr", ic_addr, 32'h1000);
`ifdef FETCH_PERF_EN
        chk("t7_async_perf_stall", perf_stall_cyc, 32'h0);
        chk("t7_async_perf_drop", perf_drop_cnt, 32'h0);
`endif
        next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    if (1) begin : g_unused_perf
        logic [31:0] unused_perf0;
        assign unused_perf0 = '0;
    end

endmodule
